// File: rtl/inference_sequencer.sv
// Inference sequencer: steps a CORDIC layer engine through NUM_LAYERS layers per
// inference, with a per-layer RUN timeout and a cycle counter for the whole inference.
//
// Ports:
//   clk         - single clock, rising edge
//   reset       - synchronous active-high reset
//   init_done   - upstream datapath is out of reset (level)
//   start       - one-cycle request to begin an inference (accepted only when ready)
//   layer_done  - one-cycle completion pulse from the layer engine
//   ready       - start will be accepted this cycle
//   busy        - inference in progress (LAUNCH or RUN)
//   layer_start - one-cycle launch pulse to the layer engine
//   layer_idx   - index of the current layer
//   infer_done  - one-cycle inference completion pulse
//   error       - sticky layer-timeout flag
//   cycle_count - LAUNCH+RUN cycles of the last or current inference, saturating
module inference_sequencer #(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic        start,
  input  logic        layer_done,
  output logic        ready,
  output logic        busy,
  output logic        layer_start,
  output logic [1:0]  layer_idx,
  output logic        infer_done,
  output logic        error,
  output logic [15:0] cycle_count
);

  localparam logic [2:0] StWaitInit = 3'd0;
  localparam logic [2:0] StIdle     = 3'd1;
  localparam logic [2:0] StLaunch   = 3'd2;
  localparam logic [2:0] StRun      = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;
  localparam logic [2:0] StError    = 3'd5;

  localparam logic [1:0] LastLayer  = 2'(NUM_LAYERS - 1);
  localparam logic [9:0] TimeoutVal = 10'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [1:0]  layer_idx_q, layer_idx_d;
  logic [9:0]  timer_q, timer_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  always_comb begin
    state_d       = state_q;
    layer_idx_d   = layer_idx_q;
    timer_d       = timer_q;
    cycle_count_d = cycle_count_q;

    if ((state_q == StLaunch || state_q == StRun) && cycle_count_q != 16'hFFFF) begin
      cycle_count_d = cycle_count_q + 16'd1;
    end

    case (state_q)
      StWaitInit: begin
        if (init_done) state_d = StIdle;
      end
      StIdle: begin
        if (start) begin
          state_d       = StLaunch;
          layer_idx_d   = 2'd0;
          cycle_count_d = 16'd0;
        end
      end
      StLaunch: begin
        // layer_done is deliberately not looked at here
        state_d = StRun;
        timer_d = 10'd0;
      end
      StRun: begin
        // layer_done takes precedence over a timeout in the same cycle
        if (layer_done) begin
          if (layer_idx_q == LastLayer) begin
            state_d = StDone;
          end else begin
            state_d     = StLaunch;
            layer_idx_d = layer_idx_q + 2'd1;
          end
        end else if (timer_q == TimeoutVal) begin
          state_d = StError;
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      StDone: begin
        state_d     = StIdle;
        layer_idx_d = 2'd0;
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StWaitInit;
      end
    endcase

    // Losing the datapath aborts anything in flight; the counter keeps its value.
    if (!init_done && state_q != StWaitInit) begin
      state_d       = StWaitInit;
      layer_idx_d   = 2'd0;
      timer_d       = 10'd0;
      cycle_count_d = cycle_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StWaitInit;
      layer_idx_q   <= 2'd0;
      timer_q       <= 10'd0;
      cycle_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      layer_idx_q   <= layer_idx_d;
      timer_q       <= timer_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign ready       = (state_q == StIdle);
  assign busy        = (state_q == StLaunch) || (state_q == StRun);
  assign layer_start = (state_q == StLaunch);
  assign infer_done  = (state_q == StDone);
  assign error       = (state_q == StError);
  assign layer_idx   = layer_idx_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer with NUM_LAYERS=3, TIMEOUT=16.
// Inputs change 1 time unit after a rising edge; outputs are read at the same point.
module tb_inference_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_done = 1'b0;
  logic        start = 1'b0;
  logic        layer_done = 1'b0;
  logic        ready, busy, layer_start, infer_done, error;
  logic [1:0]  layer_idx;
  logic [15:0] cycle_count;

  int n_cmp  = 0;
  int n_fail = 0;

  inference_sequencer #(
    .NUM_LAYERS(3),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .start      (start),
    .layer_done (layer_done),
    .ready      (ready),
    .busy       (busy),
    .layer_start(layer_start),
    .layer_idx  (layer_idx),
    .infer_done (infer_done),
    .error      (error),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; init_done = 1'b0; start = 1'b0; layer_done = 1'b0;
    tick(); tick();
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (layer_start !== 1'b0) begin n_fail++; $display("FAIL reset_layer_start got=%b want=0", layer_start); end
    n_cmp++; if (layer_idx !== 2'd0) begin n_fail++; $display("FAIL reset_layer_idx got=%0d want=0", layer_idx); end
    n_cmp++; if (infer_done !== 1'b0) begin n_fail++; $display("FAIL reset_infer_done got=%b want=0", infer_done); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b want=0", error); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL reset_cycle_count got=%0d want=0", cycle_count); end
    reset = 1'b0;
    tick();
    start = 1'b1;  // start while still waiting for init_done
    tick();
    start = 1'b0;
    n_cmp++; if (layer_start !== 1'b0) begin n_fail++; $display("FAIL bringup_early_start got=%b want=0", layer_start); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bringup_ready_before got=%b want=0", ready); end
    tick();
    init_done = 1'b1;
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bringup_ready_at_init got=%b want=0", ready); end
    tick();
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bringup_ready_after got=%b want=1", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bringup_busy got=%b want=0", busy); end
  endtask

  // Starts from IDLE; layer_done 4 cycles after each layer_start.
  task automatic test_nominal;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (layer_start !== 1'b1) begin n_fail++; $display("FAIL nom_launch%0d got=%b want=1", k, layer_start); end
      n_cmp++; if (layer_idx !== 2'(k)) begin n_fail++; $display("FAIL nom_idx%0d got=%0d want=%0d", k, layer_idx, k); end
      n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL nom_busy%0d got=%b%b want=10", k, busy, ready); end
      if (k == 0) begin
        n_cmp++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL nom_count_clear got=%0d want=0", cycle_count); end
      end
      ticks(4);
      layer_done = 1'b1;
      n_cmp++; if (layer_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL nom_run%0d got=%b%b want=01", k, layer_start, busy); end
      tick();
      layer_done = 1'b0;
    end
    n_cmp++; if (infer_done !== 1'b1) begin n_fail++; $display("FAIL nom_infer_done got=%b want=1", infer_done); end
    n_cmp++; if (busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL nom_done_flags got=%b%b want=00", busy, ready); end
    n_cmp++; if (cycle_count !== 16'd15) begin n_fail++; $display("FAIL nom_cycle_count got=%0d want=15", cycle_count); end
    tick();
    n_cmp++; if (infer_done !== 1'b0) begin n_fail++; $display("FAIL nom_done_pulse got=%b want=0", infer_done); end
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL nom_ready_back got=%b want=1", ready); end
    n_cmp++; if (layer_idx !== 2'd0) begin n_fail++; $display("FAIL nom_idx_back got=%0d want=0", layer_idx); end
    n_cmp++; if (cycle_count !== 16'd15) begin n_fail++; $display("FAIL nom_count_hold got=%0d want=15", cycle_count); end
  endtask

  task automatic test_timeout;
    start = 1'b1; tick(); start = 1'b0;
    ticks(17);  // timer now at 16
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_before got=%b%b want=01", error, busy); end
    tick();
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL to_error got=%b want=1", error); end
    n_cmp++; if (busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL to_flags got=%b%b want=00", busy, ready); end
    n_cmp++; if (cycle_count !== 16'd18) begin n_fail++; $display("FAIL to_cycle_count got=%0d want=18", cycle_count); end
    for (int i = 0; i < 20; i++) begin
      start = (i % 2 == 0);
      tick();
      n_cmp++; if (error !== 1'b1 || layer_start !== 1'b0) begin n_fail++; $display("FAIL to_sticky%0d got=%b%b want=10", i, error, layer_start); end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_in_error;
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (error !== 1'b0 || ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_err_flags got=%b%b%b want=000", error, ready, busy); end
    n_cmp++; if (layer_start !== 1'b0 || infer_done !== 1'b0) begin n_fail++; $display("FAIL rst_err_pulses got=%b%b want=00", layer_start, infer_done); end
    n_cmp++; if (layer_idx !== 2'd0 || cycle_count !== 16'd0) begin n_fail++; $display("FAIL rst_err_regs got=%0d/%0d want=0/0", layer_idx, cycle_count); end
    tick();
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_err_ready got=%b want=1", ready); end
  endtask

  task automatic test_race;
    start = 1'b1; tick(); start = 1'b0;
    layer_done = 1'b1;  // during LAUNCH: ignored
    tick();
    layer_done = 1'b0;
    n_cmp++; if (layer_idx !== 2'd0 || layer_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL race_launch_done got=%0d%b%b want=001", layer_idx, layer_start, busy); end
    ticks(16);  // timer now at 16
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    n_cmp++; if (layer_start !== 1'b1 || layer_idx !== 2'd1) begin n_fail++; $display("FAIL race_advance got=%b/%0d want=1/1", layer_start, layer_idx); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL race_error got=%b want=0", error); end
    ticks(4); layer_done = 1'b1; tick(); layer_done = 1'b0;
    n_cmp++; if (layer_start !== 1'b1 || layer_idx !== 2'd2) begin n_fail++; $display("FAIL race_layer2 got=%b/%0d want=1/2", layer_start, layer_idx); end
    ticks(4); layer_done = 1'b1; tick(); layer_done = 1'b0;
    n_cmp++; if (infer_done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL race_done got=%b%b want=10", infer_done, error); end
    n_cmp++; if (cycle_count !== 16'd28) begin n_fail++; $display("FAIL race_cycle_count got=%0d want=28", cycle_count); end
    tick();
  endtask

  task automatic test_abort;
    start = 1'b1; tick(); start = 1'b0;
    ticks(4); layer_done = 1'b1; tick(); layer_done = 1'b0;
    n_cmp++; if (layer_start !== 1'b1 || layer_idx !== 2'd1) begin n_fail++; $display("FAIL ab_layer1 got=%b/%0d want=1/1", layer_start, layer_idx); end
    tick();
    init_done = 1'b0;  // drop during layer 1 RUN
    tick();
    n_cmp++; if (busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL ab_flags got=%b%b want=00", busy, ready); end
    n_cmp++; if (layer_idx !== 2'd0) begin n_fail++; $display("FAIL ab_idx got=%0d want=0", layer_idx); end
    n_cmp++; if (infer_done !== 1'b0 || error !== 1'b0 || layer_start !== 1'b0) begin n_fail++; $display("FAIL ab_pulses got=%b%b%b want=000", infer_done, error, layer_start); end
    tick();
    n_cmp++; if (infer_done !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL ab_wait got=%b%b want=00", infer_done, ready); end
    init_done = 1'b1;
    tick();
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ab_ready got=%b want=1", ready); end
    test_nominal();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_reset_in_error();
    test_race();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3, giving the number of network layers sequenced per inference (range 1..4).
REQ-002 SHALL have parameter TIMEOUT, default 1023, giving the max RUN cycles allowed per layer before error (range 1..1023).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port init_done, input, 1 bit, level from the upstream reset sequencer; high means all datapath stages are out of reset.
REQ-006 SHALL have port start, input, 1 bit, one-cycle request to begin an inference.
REQ-007 SHALL have port layer_done, input, 1 bit, one-cycle pulse from the active CORDIC layer engine.
REQ-008 SHALL have port ready, output, 1 bit, high when start will be accepted.
REQ-009 SHALL have port busy, output, 1 bit, high while an inference is in progress.
REQ-010 SHALL have port layer_start, output, 1 bit, one-cycle launch pulse to the layer engine.
REQ-011 SHALL have port layer_idx, output, 2 bits, index of the current layer.
REQ-012 SHALL have port infer_done, output, 1 bit, one-cycle completion pulse.
REQ-013 SHALL have port error, output, 1 bit, sticky layer-timeout flag.
REQ-014 SHALL have port cycle_count, output, 16 bits, total cycles of the last or current inference.

Function
REQ-015 SHALL implement states WAIT_INIT, IDLE, LAUNCH, RUN, DONE, ERROR as a registered FSM; all outputs registered or decoded from registered state.
REQ-016 WAIT_INIT: ready=0; SHALL move to IDLE the cycle after init_done is sampled high.
REQ-017 IDLE: ready=1, busy=0; start sampled high -> LAUNCH next cycle, layer_idx=0, cycle_count cleared to 0; start SHALL be ignored in every other state.
REQ-018 LAUNCH: layer_start=1 for exactly this cycle, busy=1, per-layer timer cleared to 0; SHALL always go to RUN next cycle; layer_done SHALL be ignored in LAUNCH.
REQ-019 RUN: busy=1; if layer_done=1 and layer_idx<NUM_LAYERS-1 -> layer_idx+1, LAUNCH next cycle.
REQ-020 RUN: if layer_done=1 and layer_idx=NUM_LAYERS-1 -> DONE next cycle.
REQ-021 RUN: if layer_done=0 the timer SHALL increment; when timer equals TIMEOUT -> ERROR next cycle.
REQ-022 layer_done and timeout in the same cycle: layer_done SHALL win.
REQ-023 DONE: infer_done=1 for exactly one cycle, busy=0; SHALL return to IDLE next cycle with layer_idx=0.
REQ-024 ERROR: error=1, busy=0, ready=0; SHALL hold in ERROR until reset or init_done falls.
REQ-025 cycle_count SHALL increment every LAUNCH and RUN cycle, saturate at 16'hFFFF, and hold its value in DONE, IDLE and ERROR until the next accepted start.
REQ-026 init_done sampled low in any state other than WAIT_INIT SHALL force WAIT_INIT next cycle, clearing busy, layer_idx, error and the timer, with no infer_done pulse; cycle_count holds.
REQ-027 Latency: start accepted at cycle t -> layer_start at t+1; layer_done at cycle u -> next layer_start or infer_done at u+1.

Reset
REQ-028 reset SHALL have priority over all inputs, including init_done and start.
REQ-029 While reset is sampled high, the next state SHALL be WAIT_INIT, with ready=0, busy=0, layer_start=0, layer_idx=0, infer_done=0, error=0, cycle_count=0, and timer=0.
REQ-030 Reset asserted mid-inference SHALL abort with no infer_done or error pulse.

Verification (NUM_LAYERS=3, TIMEOUT=16)
REQ-031 Bring-up: reset 2 cycles, init_done high at cycle 5 -> ready=1 from cycle 6; a start at cycle 3 has no effect.
REQ-032 Nominal: start, with layer_done 4 cycles after each layer_start -> layer_start at idx 0, 1, 2; infer_done one cycle after the 3rd layer_done; cycle_count=15; ready returns.
REQ-033 Timeout: start, layer_done never asserted -> error=1 on the cycle after the timer reaches 16; error stays high for 20 more cycles; start is ignored.
REQ-034 Race: layer_done asserted in the same cycle the timer reaches 16 -> advances to the next layer with error=0; layer_done during LAUNCH is ignored.
REQ-035 Abort: init_done dropped during layer 1 RUN -> WAIT_INIT next cycle, busy=0, layer_idx=0, no infer_done; after init_done rises again, a new start runs normally.
REQ-036 Reset in ERROR -> all outputs return to their reset values and the FSM is in WAIT_INIT.
